// File: rtl/tube_p_pkg.sv
// Shared Tube parasite read-port definitions: FSM encodings, register indices, status bit positions.
// Imported by tube_p_rdport and tube_p_intgen.
package tube_p_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL  = 2'd1;
    localparam logic [1:0] ST_POP  = 2'd2;

    localparam logic [1:0] REG_R1 = 2'd0;
    localparam logic [1:0] REG_R2 = 2'd1;
    localparam logic [1:0] REG_R3 = 2'd2;
    localparam logic [1:0] REG_R4 = 2'd3;

    localparam int STAT_AVAIL_BIT = 7;
    localparam int STAT_NFULL_BIT = 6;

endpackage

// File: rtl/tube_p_intgen.sv
// PIRQ/PNMI generation from FIFO availability and control flags; 1-cycle registered latency.
// TUBE_PNMI_PULSE_EN: defined = fixed-width NMI pulse on each rising edge of the NMI condition, else level.
module tube_p_intgen
    import tube_p_pkg::*;
#(
    parameter int NMI_PULSE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] data_available_i,
    input  logic       r3_two_bytes_available_i,
    input  logic       ctrl_i_i,
    input  logic       ctrl_j_i,
    input  logic       ctrl_m_i,
    input  logic       ctrl_v_i,
    output logic       irq_b_o,
    output logic       nmi_b_o
);

    logic irq_b_q, irq_b_d;
    logic nmi_b_q, nmi_b_d;
    logic nmi_cond;

    assign irq_b_d = ~((ctrl_i_i & data_available_i[REG_R1]) |
                       (ctrl_j_i & data_available_i[REG_R4]));

    assign nmi_cond = ctrl_m_i & (ctrl_v_i ? r3_two_bytes_available_i
                                           : data_available_i[REG_R3]);

`ifdef TUBE_PNMI_PULSE_EN
    logic       cond_q;
    logic [2:0] cnt_q, cnt_d;

    // A new edge only starts a pulse when none is running, so it never retriggers.
    always_comb begin
        nmi_b_d = nmi_b_q;
        cnt_d   = cnt_q;
        if (!nmi_b_q) begin
            if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            else               nmi_b_d = 1'b1;
        end else if (nmi_cond && !cond_q) begin
            nmi_b_d = 1'b0;
            cnt_d   = 3'(NMI_PULSE_CYCLES - 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cond_q <= 1'b0;
            cnt_q  <= 3'd0;
        end else begin
            cond_q <= nmi_cond;
            cnt_q  <= cnt_d;
        end
    end
`else
    wire unused_pulse_len = &{1'b0, NMI_PULSE_CYCLES[2:0]};
    assign nmi_b_d = ~nmi_cond;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_b_q <= 1'b1;
            nmi_b_q <= 1'b1;
        end else begin
            irq_b_q <= irq_b_d;
            nmi_b_q <= nmi_b_d;
        end
    end

    assign irq_b_o = irq_b_q;
    assign nmi_b_o = nmi_b_q;

endmodule

// File: rtl/tube_p_rdport.sv
// Tube parasite read port: decodes CPU reads, drives FIFO selects/pop, returns data or status byte.
// Latency: status 1 cycle, data 2 cycles; accesses while busy are dropped. TUBE_PNMI_PULSE_EN selects pulse NMI.
module tube_p_rdport
    import tube_p_pkg::*;
#(
    parameter int         NMI_PULSE_CYCLES = 4,
    parameter logic [5:0] STATUS_FILL      = 6'h3F
) (
    input  logic       p_phi2,
    input  logic       p_rst,
    input  logic       p_cs_b,
    input  logic       p_rdnw,
    input  logic [2:0] p_addr,
    input  logic       p_access,
    output logic       p_busy,
    output logic [7:0] p_rd_data,
    output logic       p_rd_valid,
    output logic [3:0] p_selectData,
    output logic       p_rdstb_b,
    input  logic [7:0] p_fifo_data,
    input  logic [3:0] p_data_available,
    input  logic       p_r3_two_bytes_available,
    input  logic [3:0] p_ph_full,
    input  logic       ctrl_i,
    input  logic       ctrl_j,
    input  logic       ctrl_m,
    input  logic       ctrl_v,
    output logic       p_irq_b,
    output logic       p_nmi_b
);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic [3:0] sel_q, sel_d;
    logic       rdstb_b_q, rdstb_b_d;
    logic       accept;
    logic [1:0] n;
    logic [7:0] status_byte;

    assign n      = p_addr[2:1];
    assign accept = p_access & ~p_cs_b & p_rdnw & (state_q == ST_IDLE);

    always_comb begin
        status_byte                 = {2'b00, STATUS_FILL};
        status_byte[STAT_AVAIL_BIT] = p_data_available[n];
        status_byte[STAT_NFULL_BIT] = ~p_ph_full[n];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        sel_d      = sel_q;
        rdstb_b_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (p_addr[0]) begin
                        sel_d   = 4'b0001 << n;
                        idx_d   = n;
                        busy_d  = 1'b1;
                        state_d = ST_SEL;
                    end else begin
                        rd_data_d  = status_byte;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            // Empty FIFO: hand back whatever the quad shows, but do not pop it.
            ST_SEL: begin
                rd_data_d  = p_fifo_data;
                rd_valid_d = 1'b1;
                rdstb_b_d  = ~p_data_available[idx_q];
                state_d    = ST_POP;
            end
            ST_POP: begin
                sel_d   = 4'b0000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                sel_d   = 4'b0000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_phi2) begin
        if (p_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            busy_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            sel_q      <= 4'b0000;
            rdstb_b_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            sel_q      <= sel_d;
            rdstb_b_q  <= rdstb_b_d;
        end
    end

    assign p_busy       = busy_q;
    assign p_rd_data    = rd_data_q;
    assign p_rd_valid   = rd_valid_q;
    assign p_selectData = sel_q;
    assign p_rdstb_b    = rdstb_b_q;

    tube_p_intgen #(
        .NMI_PULSE_CYCLES(NMI_PULSE_CYCLES)
    ) u_intgen (
        .clk_i                    (p_phi2),
        .rst_i                    (p_rst),
        .data_available_i         (p_data_available),
        .r3_two_bytes_available_i (p_r3_two_bytes_available),
        .ctrl_i_i                 (ctrl_i),
        .ctrl_j_i                 (ctrl_j),
        .ctrl_m_i                 (ctrl_m),
        .ctrl_v_i                 (ctrl_v),
        .irq_b_o                  (p_irq_b),
        .nmi_b_o                  (p_nmi_b)
    );

endmodule

// File: tb/tb_tube_p_rdport.sv
// Scoreboarded bench for tube_p_rdport: directed reads push expected bytes, a monitor checks each valid pulse.
module tb_tube_p_rdport;

    localparam int NMI_W = 4;

    logic       p_phi2 = 1'b0;
    logic       p_rst, p_cs_b, p_rdnw, p_access;
    logic [2:0] p_addr;
    logic       p_busy, p_rd_valid, p_rdstb_b, p_irq_b, p_nmi_b;
    logic [7:0] p_rd_data, p_fifo_data;
    logic [3:0] p_selectData, p_data_available, p_ph_full;
    logic       p_r3_two_bytes_available;
    logic       ctrl_i, ctrl_j, ctrl_m, ctrl_v;

    int checks = 0;
    int errors = 0;
    int pops_seen = 0;
    int pops_exp = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       stb_b;
    } exp_t;
    exp_t exp_q[$];

    always #5 p_phi2 = ~p_phi2;

    tube_p_rdport #(.NMI_PULSE_CYCLES(NMI_W), .STATUS_FILL(6'h3F)) dut (
        .p_phi2(p_phi2), .p_rst(p_rst), .p_cs_b(p_cs_b), .p_rdnw(p_rdnw),
        .p_addr(p_addr), .p_access(p_access), .p_busy(p_busy),
        .p_rd_data(p_rd_data), .p_rd_valid(p_rd_valid),
        .p_selectData(p_selectData), .p_rdstb_b(p_rdstb_b),
        .p_fifo_data(p_fifo_data), .p_data_available(p_data_available),
        .p_r3_two_bytes_available(p_r3_two_bytes_available),
        .p_ph_full(p_ph_full), .ctrl_i(ctrl_i), .ctrl_j(ctrl_j),
        .ctrl_m(ctrl_m), .ctrl_v(ctrl_v), .p_irq_b(p_irq_b), .p_nmi_b(p_nmi_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge p_phi2);
        #1;
    endtask

    // Drive one access for one edge; caller pushes the expected response.
    task automatic access(input logic [2:0] a);
        p_addr   = a;
        p_cs_b   = 1'b0;
        p_rdnw   = 1'b1;
        p_access = 1'b1;
        step();
        p_access = 1'b0;
        p_cs_b   = 1'b1;
    endtask

    always @(negedge p_phi2) begin
        if (!p_rdstb_b) pops_seen++;
        if (p_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {7'd0, p_rd_valid}, 8'h00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", p_rd_data, e.data);
                check("rdstb_b_with_valid", {7'd0, p_rdstb_b}, {7'd0, e.stb_b});
            end
        end
    end

    initial begin
        p_rst = 1'b1; p_cs_b = 1'b1; p_rdnw = 1'b1; p_access = 1'b0; p_addr = 3'd0;
        p_fifo_data = 8'h00; p_data_available = 4'h0; p_ph_full = 4'h0;
        p_r3_two_bytes_available = 1'b0;
        ctrl_i = 0; ctrl_j = 0; ctrl_m = 0; ctrl_v = 0;
        repeat (3) step();
        check("rst_busy", {7'd0, p_busy}, 8'h00);
        check("rst_rd_data", p_rd_data, 8'h00);
        check("rst_sel", {4'h0, p_selectData}, 8'h00);
        check("rst_rdstb_b", {7'd0, p_rdstb_b}, 8'h01);
        check("rst_irq_nmi", {6'd0, p_irq_b, p_nmi_b}, 8'h03);
        p_rst = 1'b0;
        step();

        // R1 data read, FIFO non-empty
        p_data_available = 4'b0001; p_fifo_data = 8'hA5;
        exp_q.push_back('{data: 8'hA5, stb_b: 1'b0}); pops_exp++;
        access(3'b001);
        check("r1_sel_accept", {4'h0, p_selectData}, 8'h01);
        check("r1_busy_accept", {7'd0, p_busy}, 8'h01);
        step();
        check("r1_valid_sel", {7'd0, p_rd_valid}, 8'h01);
        step();
        check("r1_sel_idle", {4'h0, p_selectData}, 8'h00);
        check("r1_busy_idle", {7'd0, p_busy}, 8'h00);
        check("r1_rdstb_idle", {7'd0, p_rdstb_b}, 8'h01);
        check("r1_valid_onecycle", {7'd0, p_rd_valid}, 8'h00);

        // Status reads of R3
        p_data_available = 4'b0100; p_ph_full = 4'b0000;
        exp_q.push_back('{data: 8'hFF, stb_b: 1'b1});
        access(3'b100);
        check("stat_no_sel", {4'h0, p_selectData}, 8'h00);
        p_data_available = 4'b0000; p_ph_full = 4'b0100;
        exp_q.push_back('{data: 8'h3F, stb_b: 1'b1});
        access(3'b100);
        step();

        // R4 data read with empty FIFO: byte returned, no pop
        p_data_available = 4'b0000; p_fifo_data = 8'h5C; p_ph_full = 4'h0;
        exp_q.push_back('{data: 8'h5C, stb_b: 1'b1});
        access(3'b111);
        check("r4_sel", {4'h0, p_selectData}, 8'h08);
        step(); step();

        // Second access during SEL is ignored; address change has no effect
        p_data_available = 4'b0011; p_fifo_data = 8'h3C;
        exp_q.push_back('{data: 8'h3C, stb_b: 1'b0}); pops_exp++;
        access(3'b001);
        access(3'b011);
        check("ign_sel_kept", {4'h0, p_selectData}, 8'h01);
        step();
        check("ign_idle", {7'd0, p_busy}, 8'h00);
        step(); step();

        // Reset mid data read: aborted, no valid, no pop
        p_data_available = 4'b0010; p_fifo_data = 8'h77;
        access(3'b011);
        p_rst = 1'b1;
        step();
        check("mrst_valid", {7'd0, p_rd_valid}, 8'h00);
        check("mrst_rdstb_b", {7'd0, p_rdstb_b}, 8'h01);
        check("mrst_sel", {4'h0, p_selectData}, 8'h00);
        check("mrst_busy", {7'd0, p_busy}, 8'h00);
        step(); step();
        p_rst = 1'b0;
        step();
        // FSM must be IDLE: a status read is accepted straight away
        p_data_available = 4'b0000; p_ph_full = 4'b0000;
        exp_q.push_back('{data: 8'h7F, stb_b: 1'b1});
        access(3'b000);
        step();

        // IRQ
        ctrl_i = 1; p_data_available = 4'b0000;
        step();
        check("irq_idle", {7'd0, p_irq_b}, 8'h01);
        p_data_available = 4'b0001;
        step();
        check("irq_r1", {7'd0, p_irq_b}, 8'h00);
        ctrl_i = 0;
        step();
        check("irq_off", {7'd0, p_irq_b}, 8'h01);
        ctrl_j = 1; p_data_available = 4'b1000;
        step();
        check("irq_r4", {7'd0, p_irq_b}, 8'h00);
        ctrl_j = 0; p_data_available = 4'b0000;
        step();

        // NMI: two-byte mode waits for two bytes
        ctrl_m = 1; ctrl_v = 1; p_data_available = 4'b0100; p_r3_two_bytes_available = 0;
        step(); step();
        check("nmi_wait_two", {7'd0, p_nmi_b}, 8'h01);
        p_r3_two_bytes_available = 1;
        step();
        check("nmi_low_0", {7'd0, p_nmi_b}, 8'h00);
        for (int i = 1; i < NMI_W; i++) begin
            step();
            check("nmi_low_n", {7'd0, p_nmi_b}, 8'h00);
        end
        step();
`ifdef TUBE_PNMI_PULSE_EN
        check("nmi_pulse_end", {7'd0, p_nmi_b}, 8'h01);
        step();
        check("nmi_no_retrig", {7'd0, p_nmi_b}, 8'h01);
`else
        check("nmi_level_hold", {7'd0, p_nmi_b}, 8'h00);
        p_r3_two_bytes_available = 0;
        step();
        check("nmi_level_release", {7'd0, p_nmi_b}, 8'h01);
`endif
        ctrl_m = 0; ctrl_v = 0;
        repeat (3) step();

        check("pop_count", 8'(pops_seen), 8'(pops_exp));
        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
